// File: rtl/prog_mem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : prog_mem_loader                                            |
// | Description : Unified instruction/data memory for the HMMM-style core    |
// |               with an SPI mode-0 slave program-load port. Owns the core  |
// |               reset: the core is held in reset while a program is being  |
// |               loaded and for a short release period afterwards.          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk          in   1     system clock, all state on posedge             |
// |   reset        in   1     asynchronous, active-high                      |
// |   cpu_adr      in   AW    core address                                   |
// |   cpu_we       in   1     core write enable (honoured in RUN only)       |
// |   cpu_wdata    in   CW    core write data, stored zero-extended to DW    |
// |   cpu_rdata    out  DW    mem[cpu_adr], combinational                    |
// |   cpu_reset    out  1     registered active-high reset to the core       |
// |   load_mode    in   1     async pin, 1 = program-load mode               |
// |   spi_sck      in   1     async serial clock, sampled on rising edge     |
// |   spi_sdi      in   1     async serial data, MSB first                   |
// |   spi_cs_n     in   1     async frame select, active-low                 |
// |   load_done    out  1     one-cycle pulse per frame written              |
// |   words_loaded out  AW+1  frames written since entering LOAD (saturates) |
// +--------------------------------------------------------------------------+
module prog_mem_loader #(
   parameter int AW             = 8,
   parameter int DW             = 15,
   parameter int CW             = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int RELEASE_CYCLES = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] cpu_adr,
   input  logic          cpu_we,
   input  logic [CW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_reset,
   input  logic          load_mode,
   input  logic          spi_sck,
   input  logic          spi_sdi,
   input  logic          spi_cs_n,
   output logic          load_done,
   output logic [AW:0]   words_loaded
);

   // Frame layout, MSB first: {addr[AW-1:0], pad, data[DW-1:0]}
   localparam int c_fw    = AW + 1 + DW;
   localparam int c_bcw   = $clog2(c_fw);
   localparam int c_rcw   = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
   localparam int c_depth = 2 ** AW;

   localparam logic [c_bcw-1:0] c_last_bit = c_bcw'(c_fw - 1);
   localparam logic [c_rcw-1:0] c_rel_last = c_rcw'(RELEASE_CYCLES - 1);
   localparam logic [AW:0]      c_words_max = {1'b1, {AW{1'b0}}};

   localparam logic [1:0] c_st_run     = 2'd0;
   localparam logic [1:0] c_st_load    = 2'd1;
   localparam logic [1:0] c_st_release = 2'd2;

   // -----------------------------------------------------------------------
   // Input synchronizers. Bit order per stage: {cs_n, sdi, sck, load_mode}.
   // All four pins travel through the same pipeline so that sdi and cs_n
   // stay aligned with the sck edge they belong to.
   // -----------------------------------------------------------------------
   logic [3:0] r_sync [SYNC_STAGES];
   logic       r_sck_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= '0;
         end
         r_sck_d <= 1'b0;
      end else begin
         r_sync[0] <= {spi_cs_n, spi_sdi, spi_sck, load_mode};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_sck_d <= r_sync[SYNC_STAGES-1][1];
      end
   end

   logic w_load_s;
   logic w_sck_s;
   logic w_sdi_s;
   logic w_cs_n_s;
   logic w_sck_rise;

   assign w_load_s   = r_sync[SYNC_STAGES-1][0];
   assign w_sck_s    = r_sync[SYNC_STAGES-1][1];
   assign w_sdi_s    = r_sync[SYNC_STAGES-1][2];
   assign w_cs_n_s   = r_sync[SYNC_STAGES-1][3];
   assign w_sck_rise = w_sck_s & ~r_sck_d;

   // -----------------------------------------------------------------------
   // Mode FSM
   // -----------------------------------------------------------------------
   logic [1:0]       r_state;
   logic [1:0]       w_state_next;
   logic [c_rcw-1:0] r_rel_cnt;
   logic             r_cpu_reset;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_run: begin
            if (w_load_s) w_state_next = c_st_load;
         end
         c_st_load: begin
            if (!w_load_s) w_state_next = c_st_release;
         end
         c_st_release: begin
            // Re-entering LOAD wins over finishing the release count
            if (w_load_s)                    w_state_next = c_st_load;
            else if (r_rel_cnt == c_rel_last) w_state_next = c_st_run;
         end
         default: w_state_next = c_st_release;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= c_st_release;
         r_rel_cnt   <= '0;
         r_cpu_reset <= 1'b1;
      end else begin
         r_state <= w_state_next;
         // Registered from the next state so cpu_reset changes on the same
         // edge the FSM enters or leaves RUN.
         r_cpu_reset <= (w_state_next != c_st_run);
         if (r_state == c_st_release && w_state_next == c_st_release) begin
            r_rel_cnt <= r_rel_cnt + c_rcw'(1);
         end else begin
            r_rel_cnt <= '0;
         end
      end
   end

   // -----------------------------------------------------------------------
   // SPI frame receiver
   // -----------------------------------------------------------------------
   logic [c_fw-1:0]  r_shift;
   logic [c_bcw-1:0] r_bit_cnt;
   logic             r_load_done;
   logic [AW:0]      r_words;

   logic             w_spi_open;
   logic             w_spi_accept;
   logic             w_frame_end;
   logic             w_enter_load;
   logic [c_fw-1:0]  w_frame;
   logic [AW-1:0]    w_frame_addr;
   logic [DW-1:0]    w_frame_data;

   // A frame may only progress while we stay in LOAD with cs_n low; any
   // other condition (deselect, leaving LOAD) throws the partial frame away.
   assign w_spi_open   = (r_state == c_st_load) && (w_state_next == c_st_load) && !w_cs_n_s;
   assign w_spi_accept = w_spi_open && w_sck_rise;
   assign w_frame_end  = w_spi_accept && (r_bit_cnt == c_last_bit);
   assign w_enter_load = (r_state != c_st_load) && (w_state_next == c_st_load);

   // The completed frame includes the bit arriving on this very sck edge
   assign w_frame      = {r_shift[c_fw-2:0], w_sdi_s};
   assign w_frame_addr = w_frame[c_fw-1 -: AW];
   assign w_frame_data = w_frame[DW-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_load_done <= 1'b0;
         r_words     <= '0;
      end else begin
         r_load_done <= w_frame_end;

         if (w_spi_accept) begin
            r_shift <= w_frame;
         end

         if (!w_spi_open || w_frame_end) begin
            r_bit_cnt <= '0;
         end else if (w_sck_rise) begin
            r_bit_cnt <= r_bit_cnt + c_bcw'(1);
         end

         if (w_enter_load) begin
            r_words <= '0;
         end else if (w_frame_end && r_words != c_words_max) begin
            r_words <= r_words + (AW+1)'(1);
         end
      end
   end

   // Pad bit of the frame and the oldest shift bit carry no information
   logic w_unused_bits;
   assign w_unused_bits = ^{r_shift[c_fw-1], w_frame[DW]};

   // -----------------------------------------------------------------------
   // Memory: single write port muxed between core (RUN) and SPI (LOAD).
   // The two sources are never active in the same state. Not reset.
   // -----------------------------------------------------------------------
   logic [DW-1:0] r_mem [c_depth];

   logic          w_core_we;
   logic          w_mem_we;
   logic [AW-1:0] w_mem_addr;
   logic [DW-1:0] w_mem_wdata;

   assign w_core_we = (r_state == c_st_run) && cpu_we;

   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_addr  = cpu_adr;
      w_mem_wdata = {{(DW-CW){1'b0}}, cpu_wdata};
      if (w_frame_end) begin
         w_mem_we    = 1'b1;
         w_mem_addr  = w_frame_addr;
         w_mem_wdata = w_frame_data;
      end else if (w_core_we) begin
         w_mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

   assign cpu_rdata    = r_mem[cpu_adr];
   assign cpu_reset    = r_cpu_reset;
   assign load_done    = r_load_done;
   assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_prog_mem_loader                                         |
// | Description : Self-checking bench for prog_mem_loader: table of SPI      |
// |               frames with expected readback plus directed sequences for  |
// |               reset release, cs_n abort, core writes, load entry latency |
// |               and reset in the middle of a frame.                        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_prog_mem_loader;

   logic        clk;
   logic        reset;
   logic [7:0]  cpu_adr;
   logic        cpu_we;
   logic [7:0]  cpu_wdata;
   logic [14:0] cpu_rdata;
   logic        cpu_reset;
   logic        load_mode;
   logic        spi_sck;
   logic        spi_sdi;
   logic        spi_cs_n;
   logic        load_done;
   logic [8:0]  words_loaded;

   prog_mem_loader dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_adr      (cpu_adr),
      .cpu_we       (cpu_we),
      .cpu_wdata    (cpu_wdata),
      .cpu_rdata    (cpu_rdata),
      .cpu_reset    (cpu_reset),
      .load_mode    (load_mode),
      .spi_sck      (spi_sck),
      .spi_sdi      (spi_sdi),
      .spi_cs_n     (spi_cs_n),
      .load_done    (load_done),
      .words_loaded (words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   always @(negedge clk) begin
      if (load_done === 1'b1) done_cnt++;
   end

   typedef struct {
      logic [7:0]  addr;
      logic [14:0] data;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // SPI mode 0, MSB first; sck half period of 6 clk leaves headroom over the
   // synchronizer requirement. cs_n is left low for the caller to release.
   task automatic spi_shift(input logic [23:0] frame, input int nbits);
      spi_cs_n = 1'b0;
      tick(6);
      for (int i = 0; i < nbits; i++) begin
         spi_sdi = frame[23-i];
         tick(6);
         spi_sck = 1'b1;
         tick(6);
         spi_sck = 1'b0;
      end
      tick(6);
   endtask

   task automatic wait_cpu_reset(input logic lvl, input int budget, output int cycles);
      cycles = 0;
      while (cpu_reset !== lvl && cycles < budget) begin
         tick(1);
         cycles++;
      end
   endtask

   function automatic logic [23:0] mk_frame(input logic [7:0] a, input logic [14:0] d);
      return {a, 1'b0, d};
   endfunction

   initial begin
      int cyc;
      int done_base;

      vecs[0] = '{8'h05, 15'h1234};
      vecs[1] = '{8'h20, 15'h7FFF};
      vecs[2] = '{8'hFF, 15'h5555};
      vecs[3] = '{8'h00, 15'h0001};
      vecs[4] = '{8'h80, 15'h2AAA};

      reset     = 1'b1;
      load_mode = 1'b0;
      spi_sck   = 1'b0;
      spi_sdi   = 1'b0;
      spi_cs_n  = 1'b1;
      cpu_we    = 1'b0;
      cpu_adr   = 8'h00;
      cpu_wdata = 8'h00;

      // ---- reset values and release timing ----
      tick(3);
      check("reset_cpu_reset", cpu_reset, 1);
      check("reset_load_done", load_done, 0);
      check("reset_words", words_loaded, 0);
      reset = 1'b0;
      tick(1);
      check("release_cycle1", cpu_reset, 1);
      tick(1);
      check("release_cycle2_run", cpu_reset, 0);
      tick(10);
      check("run_stays", cpu_reset, 0);
      check("no_done_pulse", done_cnt, 0);

      // ---- table-driven frame load ----
      load_mode = 1'b1;
      wait_cpu_reset(1'b1, 20, cyc);
      check("enter_load", cpu_reset, 1);
      tick(2);
      for (int i = 0; i < 5; i++) begin
         done_base = done_cnt;
         spi_shift(mk_frame(vecs[i].addr, vecs[i].data), 24);
         check($sformatf("words_after_frame%0d", i), words_loaded, i + 1);
         check($sformatf("done_pulse_frame%0d", i), done_cnt - done_base, 1);
      end
      spi_cs_n  = 1'b1;
      load_mode = 1'b0;
      wait_cpu_reset(1'b0, 20, cyc);
      check("released_after_load", cpu_reset, 0);
      for (int i = 0; i < 5; i++) begin
         cpu_adr = vecs[i].addr;
         #1;
         check($sformatf("readback_%0h", vecs[i].addr), cpu_rdata, vecs[i].data);
      end

      // ---- cs_n abort after 10 bits, then full frame ----
      load_mode = 1'b1;
      wait_cpu_reset(1'b1, 20, cyc);
      tick(2);
      check("words_cleared_on_entry", words_loaded, 0);
      done_base = done_cnt;
      spi_shift(mk_frame(8'h33, 15'h1111), 10);
      spi_cs_n = 1'b1;
      tick(8);
      spi_shift(mk_frame(8'h07, 15'h7FFF), 24);
      spi_cs_n = 1'b1;
      check("abort_words", words_loaded, 1);
      check("abort_done_pulses", done_cnt - done_base, 1);
      load_mode = 1'b0;
      wait_cpu_reset(1'b0, 20, cyc);
      cpu_adr = 8'h07;
      #1;
      check("abort_mem7", cpu_rdata, 15'h7FFF);
      cpu_adr = 8'h05;
      #1;
      check("abort_mem5_kept", cpu_rdata, 15'h1234);

      // ---- core write zero-extends over a full-width word ----
      cpu_adr = 8'h20;
      #1;
      check("core_prior", cpu_rdata, 15'h7FFF);
      cpu_wdata = 8'hA5;
      cpu_we    = 1'b1;
      tick(1);
      cpu_we = 1'b0;
      check("core_write_20", cpu_rdata, 15'h00A5);
      cpu_adr   = 8'h00;
      cpu_wdata = 8'hFF;
      cpu_we    = 1'b1;
      tick(1);
      cpu_we = 1'b0;
      check("core_write_00", cpu_rdata, 15'h00FF);

      // ---- load_mode rises during core writes ----
      cpu_adr   = 8'h40;
      cpu_wdata = 8'h3C;
      cpu_we    = 1'b1;
      load_mode = 1'b1;
      wait_cpu_reset(1'b1, 10, cyc);
      check("load_entry_reset", cpu_reset, 1);
      check("load_entry_latency_ok", (cyc >= 1 && cyc <= 3) ? 1 : 0, 1);
      cpu_adr   = 8'h05;
      cpu_wdata = 8'h99;
      tick(4);
      cpu_we = 1'b0;
      check("we_ignored_in_load", cpu_rdata, 15'h1234);
      cpu_adr = 8'h40;
      #1;
      check("run_write_before_load", cpu_rdata, 15'h003C);

      // ---- reset in the middle of a frame ----
      spi_shift(mk_frame(8'h05, 15'h0ABC), 12);
      reset = 1'b1;
      tick(1);
      check("midframe_reset_cpu_reset", cpu_reset, 1);
      check("midframe_reset_words", words_loaded, 0);
      check("midframe_reset_done", load_done, 0);
      spi_cs_n = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(10);
      check("reload_after_reset", cpu_reset, 1);
      done_base = done_cnt;
      spi_shift(mk_frame(8'h0B, 15'h0123), 24);
      spi_cs_n = 1'b1;
      check("post_reset_words", words_loaded, 1);
      check("post_reset_done", done_cnt - done_base, 1);
      load_mode = 1'b0;
      wait_cpu_reset(1'b0, 20, cyc);
      check("final_release", cpu_reset, 0);
      cpu_adr = 8'h0B;
      #1;
      check("post_reset_mem0b", cpu_rdata, 15'h0123);
      cpu_adr = 8'h05;
      #1;
      check("preserved_mem05", cpu_rdata, 15'h1234);
      cpu_adr = 8'hFF;
      #1;
      check("preserved_memff", cpu_rdata, 15'h5555);
      cpu_adr = 8'h20;
      #1;
      check("preserved_mem20", cpu_rdata, 15'h00A5);
      check("total_done_pulses", done_cnt, 7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
